// File: rtl/ws_array_sequencer_pkg.sv
// rtl/ws_array_sequencer_pkg.sv - shared types and constants for ws_array_sequencer
// Package ws_seq_pkg: sequencer state enum, default geometry, tag delay
// depth, job cycle counter width and small helper functions.
package ws_seq_pkg;

  localparam int ARRAY_DIM_DEF = 4;
  localparam int ADDR_W_DEF    = 8;
  localparam int OUT_LAT_DEF   = 9;

  // Valid/index delay line depth: the last column taps OUT_LAT+ARRAY_DIM-1
  // cycles after the activation read.
  localparam int DLY_DEPTH = OUT_LAT_DEF + ARRAY_DIM_DEF - 1;

  localparam int JOB_CYC_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LATCH,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } seq_state_t;

  function automatic int dly_depth(input int out_lat, input int dim);
    return out_lat + dim - 1;
  endfunction

  function automatic logic [JOB_CYC_W-1:0] sat_inc(input logic [JOB_CYC_W-1:0] x);
    return (&x) ? x : x + JOB_CYC_W'(1);
  endfunction

endpackage

// File: rtl/ws_array_sequencer_if.sv
// rtl/ws_array_sequencer_if.sv - host, SRAM and array-control bus of ws_array_sequencer
// Signals:
//   start, abort, num_vecs            host -> sequencer job control
//   busy, done                        sequencer -> host status
//   w_rd_en/w_rd_addr                 weight SRAM read
//   a_rd_en/a_rd_addr                 activation SRAM read
//   fsm_op2_select, stat_bit,
//   fsm_out_select                    broadcast PE array controls
//   out_valid, out_vec_idx            per-column result tags
// Modports: master (sequencer side), slave (host/array side).
interface ws_array_sequencer_if #(
  parameter int ARRAY_DIM = ws_seq_pkg::ARRAY_DIM_DEF,
  parameter int ADDR_W    = ws_seq_pkg::ADDR_W_DEF
);
  logic                          start;
  logic                          abort;
  logic [ADDR_W-1:0]             num_vecs;
  logic                          busy;
  logic                          done;
  logic                          w_rd_en;
  logic [ADDR_W-1:0]             w_rd_addr;
  logic                          a_rd_en;
  logic [ADDR_W-1:0]             a_rd_addr;
  logic                          fsm_op2_select;
  logic                          stat_bit;
  logic                          fsm_out_select;
  logic [ARRAY_DIM-1:0]          out_valid;
  logic [ARRAY_DIM*ADDR_W-1:0]   out_vec_idx;

  modport master (
    input  start, abort, num_vecs,
    output busy, done, w_rd_en, w_rd_addr, a_rd_en, a_rd_addr,
           fsm_op2_select, stat_bit, fsm_out_select, out_valid, out_vec_idx
  );

  modport slave (
    output start, abort, num_vecs,
    input  busy, done, w_rd_en, w_rd_addr, a_rd_en, a_rd_addr,
           fsm_op2_select, stat_bit, fsm_out_select, out_valid, out_vec_idx
  );
endinterface

// File: rtl/ws_array_sequencer_tag_delay.sv
// rtl/ws_array_sequencer_tag_delay.sv - valid/vector-index delay line with synchronous flush
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   flush         clears every stage on the next edge
//   in_valid      activation read issued this cycle
//   in_idx        vector index of that read
//   out_valid     bit c: stage OUT_LAT+c-1 valid (result at bottom of column c)
//   out_idx       slice c: vector index held in that stage
module seq_tag_delay
  import ws_seq_pkg::*;
#(
  parameter int ARRAY_DIM = ARRAY_DIM_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int OUT_LAT   = OUT_LAT_DEF,
  parameter int DEPTH     = DLY_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic [ADDR_W-1:0]           in_idx,
  output logic [ARRAY_DIM-1:0]        out_valid,
  output logic [ARRAY_DIM*ADDR_W-1:0] out_idx
);

  logic [DEPTH-1:0]             v_sr;
  logic [DEPTH-1:0][ADDR_W-1:0] idx_sr;

  // Stage k holds the tag of the read issued k+1 cycles ago. Indices are
  // zeroed when not valid so idle columns show a clean 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_sr   <= '0;
      idx_sr <= '0;
    end else if (flush) begin
      v_sr   <= '0;
      idx_sr <= '0;
    end else begin
      v_sr   <= {v_sr[DEPTH-2:0], in_valid};
      idx_sr <= {idx_sr[DEPTH-2:0], (in_valid ? in_idx : '0)};
    end
  end

  for (genvar c = 0; c < ARRAY_DIM; c++) begin : g_tap
    assign out_valid[c]                = v_sr[OUT_LAT+c-1];
    assign out_idx[c*ADDR_W +: ADDR_W] = idx_sr[OUT_LAT+c-1];
  end

endmodule

// File: rtl/ws_array_sequencer.sv
// rtl/ws_array_sequencer.sv - weight-stationary systolic array job sequencer
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   bus           ws_array_sequencer_if.master: host control/status, weight
//                 and activation SRAM reads, array broadcast controls and
//                 per-column result tags
//   job_cycles    (only with SEQ_PERF_CNT_EN) cycles of the last completed
//                 job, start cycle through DONE cycle, saturating
module ws_array_sequencer
  import ws_seq_pkg::*;
#(
  parameter int ARRAY_DIM = ARRAY_DIM_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int OUT_LAT   = OUT_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  ws_array_sequencer_if.master bus
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [JOB_CYC_W-1:0] job_cycles
`endif
);

  seq_state_t           state, state_n;
  logic [ADDR_W-1:0]    cnt;
  logic [ADDR_W-1:0]    nv_reg;

  logic                 busy, done, w_rd_en, a_rd_en;
  logic [ADDR_W-1:0]    w_rd_addr, a_rd_addr;
  logic                 op2_sel, stat_bit, out_sel;
  logic                 flush;
  logic [ARRAY_DIM-1:0]        tag_valid;
  logic [ARRAY_DIM*ADDR_W-1:0] tag_idx;
  logic                 last_col_done;

  // The last vector leaves the last column: DONE follows next cycle.
  assign last_col_done = tag_valid[ARRAY_DIM-1] &&
                         (tag_idx[(ARRAY_DIM-1)*ADDR_W +: ADDR_W] == nv_reg - ADDR_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      nv_reg <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && bus.start)
        nv_reg <= bus.num_vecs;
      // cnt restarts at every state change, so it indexes within a phase.
      if (state_n != state)
        cnt <= '0;
      else if (state == S_LOAD_W || state == S_COMPUTE)
        cnt <= cnt + ADDR_W'(1);
    end
  end

  always_comb begin
    state_n   = state;
    busy      = 1'b1;
    done      = 1'b0;
    w_rd_en   = 1'b0;
    w_rd_addr = '0;
    a_rd_en   = 1'b0;
    a_rd_addr = '0;
    op2_sel   = 1'b0;
    stat_bit  = 1'b0;
    out_sel   = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (bus.start) state_n = S_LOAD_W;
      end
      S_LOAD_W: begin
        // Last row first so each row's weights reach their PE together.
        w_rd_en   = 1'b1;
        w_rd_addr = ADDR_W'(ARRAY_DIM-1) - cnt;
        if (cnt == ADDR_W'(ARRAY_DIM-1)) state_n = S_LATCH;
      end
      S_LATCH: begin
        op2_sel = 1'b1;
        state_n = (nv_reg == '0) ? S_DONE : S_COMPUTE;
      end
      S_COMPUTE: begin
        a_rd_en   = 1'b1;
        a_rd_addr = cnt;
        stat_bit  = 1'b1;
        out_sel   = 1'b1;
        if (cnt == nv_reg - ADDR_W'(1)) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        stat_bit = 1'b1;
        out_sel  = 1'b1;
        if (last_col_done) state_n = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_n = S_IDLE;
      end
    endcase
    if (bus.abort && state != S_IDLE) state_n = S_IDLE;
  end

  assign flush = bus.abort && (state != S_IDLE);

  seq_tag_delay #(
    .ARRAY_DIM (ARRAY_DIM),
    .ADDR_W    (ADDR_W),
    .OUT_LAT   (OUT_LAT),
    .DEPTH     (dly_depth(OUT_LAT, ARRAY_DIM))
  ) u_tag_delay (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (a_rd_en),
    .in_idx    (a_rd_addr),
    .out_valid (tag_valid),
    .out_idx   (tag_idx)
  );

  assign bus.busy           = busy;
  assign bus.done           = done;
  assign bus.w_rd_en        = w_rd_en;
  assign bus.w_rd_addr      = w_rd_addr;
  assign bus.a_rd_en        = a_rd_en;
  assign bus.a_rd_addr      = a_rd_addr;
  assign bus.fsm_op2_select = op2_sel;
  assign bus.stat_bit       = stat_bit;
  assign bus.fsm_out_select = out_sel;
  assign bus.out_valid      = tag_valid;
  assign bus.out_vec_idx    = tag_idx;

`ifdef SEQ_PERF_CNT_EN
  logic [JOB_CYC_W-1:0] run_cnt;
  logic [JOB_CYC_W-1:0] job_cycles_r;

  // run_cnt equals the number of job cycles already elapsed; the DONE cycle
  // itself is added when the result is committed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt      <= '0;
      job_cycles_r <= '0;
    end else begin
      if (state == S_IDLE)
        run_cnt <= bus.start ? JOB_CYC_W'(1) : '0;
      else
        run_cnt <= sat_inc(run_cnt);
      if (state == S_DONE)
        job_cycles_r <= sat_inc(run_cnt);
    end
  end

  assign job_cycles = job_cycles_r;
`endif

endmodule

// File: tb/tb_ws_array_sequencer.sv
// tb/tb_ws_array_sequencer.sv - self-checking bench for ws_array_sequencer
// Optional SEQ_PERF_CNT_EN adds job_cycles checks.
module tb_ws_array_sequencer;
  import ws_seq_pkg::*;

  localparam int DIM = 4;
  localparam int AW  = 8;
  localparam int LAT = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ws_array_sequencer_if #(.ARRAY_DIM(DIM), .ADDR_W(AW)) bus();

`ifdef SEQ_PERF_CNT_EN
  logic [JOB_CYC_W-1:0] job_cycles;
  int exp_jc = 0;
`endif

  ws_array_sequencer #(.ARRAY_DIM(DIM), .ADDR_W(AW), .OUT_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef SEQ_PERF_CNT_EN
    ,
    .job_cycles (job_cycles)
`endif
  );

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic          a_en;
    logic [AW-1:0] a_addr;
    logic          op2;
    logic          stat;
    logic          osel;
    logic [DIM-1:0]    ov;
    logic [DIM*AW-1:0] idx;
  } obs_t;

  obs_t exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic obs_t sample();
    obs_t o;
    o.busy   = bus.busy;
    o.done   = bus.done;
    o.w_en   = bus.w_rd_en;
    o.w_addr = bus.w_rd_addr;
    o.a_en   = bus.a_rd_en;
    o.a_addr = bus.a_rd_addr;
    o.op2    = bus.fsm_op2_select;
    o.stat   = bus.stat_bit;
    o.osel   = bus.fsm_out_select;
    o.ov     = bus.out_valid;
    o.idx    = bus.out_vec_idx;
    return o;
  endfunction

  function automatic int done_cycle(input int nv);
    return (nv == 0) ? DIM + 2 : 2*DIM + 1 + nv + LAT;
  endfunction

  // Reference timeline of one job; start accepted in cycle 0, abort (if ab>=1)
  // in cycle ab makes cycle ab+1 onwards idle.
  function automatic obs_t model(input int k, input int nv, input int ab);
    obs_t e;
    int d, endc;
    e = '0;
    d = done_cycle(nv);
    endc = (ab >= 1 && ab < d) ? ab : d;
    if (k < 1 || k > endc) return e;
    e.busy = 1'b1;
    if (k == d) e.done = 1'b1;
    else if (k <= DIM) begin
      e.w_en = 1'b1; e.w_addr = AW'(DIM - k);
    end else if (k == DIM + 1) e.op2 = 1'b1;
    else if (k <= DIM + 1 + nv) begin
      e.a_en = 1'b1; e.a_addr = AW'(k - DIM - 2); e.stat = 1'b1; e.osel = 1'b1;
    end else begin
      e.stat = 1'b1; e.osel = 1'b1;
    end
    for (int c = 0; c < DIM; c++)
      for (int v = 0; v < nv; v++)
        if (k == DIM + 2 + v + LAT + c) begin
          e.ov[c] = 1'b1;
          e.idx[c*AW +: AW] = AW'(v);
        end
    return e;
  endfunction

  // Runs one job from its start cycle; cut>=0 stops before cycle cut.
  task automatic run_job(input string name, input int nv, input int ab,
                         input int restart, input int cut);
    int d, last;
    obs_t o, e;
    bit full;
    d = done_cycle(nv);
    last = (ab >= 1 && ab < d) ? ab + 1 : d + 1;
    full = (ab < 1 || ab >= d);
    if (cut >= 0 && cut - 1 < last) begin
      last = cut - 1;
      full = 1'b0;
    end
    for (int k = 0; k <= last; k++) exp_q.push_back(model(k, nv, ab));
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      o = sample();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s cyc%0d got=%h want=%h", name, k, o, e);
      end
      bus.start    = (k == 0) || (k == restart);
      bus.abort    = (k == ab);
      bus.num_vecs = (k == 0) ? AW'(nv) : AW'($urandom_range(0, 255));
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
`ifdef SEQ_PERF_CNT_EN
    if (full) exp_jc = d + 1;
    if (cut < 0) begin
      checks++;
      if (job_cycles !== JOB_CYC_W'(exp_jc)) begin
        errors++;
        $display("FAIL %s job_cycles got=%0d want=%0d", name, job_cycles, exp_jc);
      end
    end
`else
    if (full && cut >= 0) $display("note: %s ran uncut", name);
`endif
  endtask

  task automatic check_idle(input string name);
    obs_t o;
    o = sample();
    checks++;
    if (o !== obs_t'(0)) begin
      errors++;
      $display("FAIL %s got=%h want=0", name, o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_idle("reset_outputs");
`ifdef SEQ_PERF_CNT_EN
    checks++;
    if (job_cycles !== '0) begin
      errors++;
      $display("FAIL reset_job_cycles got=%0d want=0", job_cycles);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
    check_idle("after_reset_release");
  endtask

  task automatic test_basic_job();
    run_job("nv3", 3, -1, -1, -1);
    run_job("nv1", 1, -1, -1, -1);
  endtask

  task automatic test_zero_vecs();
    run_job("nv0", 0, -1, -1, -1);
  endtask

  task automatic test_start_ignored();
    run_job("restart_ignored", 3, -1, 7, -1);
  endtask

  task automatic test_abort();
    run_job("abort_c7", 3, 7, -1, -1);
    run_job("after_abort", 2, -1, -1, -1);
    run_job("abort_drain", 3, 16, -1, -1);
  endtask

  task automatic test_start_abort_idle();
    run_job("start_abort_idle", 2, 0, -1, -1);
  endtask

  task automatic test_back_to_back();
    run_job("b2b_a", 6, -1, -1, -1);
    run_job("b2b_b", 5, -1, -1, -1);
  endtask

  task automatic test_rst_mid();
    run_job("rst_mid_pre", 3, -1, -1, 16);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle("rst_mid_async");
    @(negedge clk);
    rst = 1'b0;
`ifdef SEQ_PERF_CNT_EN
    exp_jc = 0;
    checks++;
    if (job_cycles !== '0) begin
      errors++;
      $display("FAIL rst_mid_job_cycles got=%0d want=0", job_cycles);
    end
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("rst_mid_idle");
    end
    run_job("after_rst", 3, -1, -1, -1);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.num_vecs = '0;
    test_reset();
    test_basic_job();
    test_zero_vecs();
    test_start_ignored();
    test_abort();
    test_start_abort_idle();
    test_back_to_back();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
